datamem_arbiter: RTL and testbench
==================================

Name: datamem_arbiter

Overview:
Sequences and shares the 8-bit data memory between two requesters: port A (CPU load/store unit) and port B (display scan engine reading the snake grid).
Converts one-shot request/ack transactions into the memory's control pulses: address-load (c_memaddr), then read (c_dataread) or write (c_datawrite).
Sits between the requesters and the data memory. It is the only driver of the memory's control inputs and the memory's bus_in.
Also blocks writes to the button-mapped address so that memory location can never be corrupted.

Parameters:
PRIO_MODE, 0, 0 = round-robin between A and B; 1 = fixed priority with A always winning.
PROT_ADDR, 8'hFF, read-only address (button register); writes to it are suppressed and flagged.
PROT_EN, 1, 1 = enable write protection on PROT_ADDR; 0 = no protected address.

Ports:
clk  in  1  system clock, all logic on rising edge
reset  in  1  synchronous, active-low; reset==0 at a rising edge resets the block
a_req  in  1  port A request; held high until a_ack
a_we  in  1  port A: 1 = write, 0 = read
a_addr  in  8  port A address
a_wdata  in  8  port A write data
a_rdata  out  8  port A read data, valid while a_ack=1
a_ack  out  1  port A one-cycle completion pulse
a_err  out  1  port A protected-write flag, valid while a_ack=1
b_req, b_we, b_addr, b_wdata, b_rdata, b_ack, b_err  same widths and meanings as port A, for port B
mem_wdata  out  8  drives the memory's bus_in
mem_rdata  in  8  from the memory's bus_out
c_memaddr  out  1  memory address-register load strobe
c_dataread  out  1  memory read enable
c_datawrite  out  1  memory write strobe
owner  out  1  current/last granted port: 0 = A, 1 = B
busy  out  1  high in every state except IDLE

Behaviour:
- Reset (reset==0 at an edge):
  - state goes to IDLE.
  - All outputs go to 0: a_ack, b_ack, a_err, b_err, a_rdata, b_rdata, mem_wdata, c_memaddr, c_dataread, c_datawrite, busy.
  - owner goes to 1, so port A wins the first round-robin tie.
  - A transaction in progress is abandoned with no ack.
  - Reset applied during DATA of a write drops the write: c_datawrite is 0 in the cycle after the reset edge.
- FSM states: IDLE, ADDR, DATA, ACK. All control outputs are registered, decoded from state plus latched transaction fields.
- IDLE:
  - If any req is high at the edge, the arbiter picks a winner and latches its we, addr and wdata. Next state is ADDR; owner is updated.
  - Otherwise it stays in IDLE.
- Arbitration:
  - PRIO_MODE=0: if both requests are high, the winner is the port that is not owner. If only one is high, that port wins.
  - PRIO_MODE=1: A wins whenever a_req is high.
- ADDR (1 cycle): c_memaddr=1, mem_wdata=latched addr. Next state is DATA.
- DATA (1 cycle), write:
  - Normal case: c_datawrite=1, mem_wdata=latched wdata.
  - If PROT_EN=1 and addr==PROT_ADDR: c_datawrite stays 0 and the error flag is set.
- DATA (1 cycle), read: c_dataread=1. mem_rdata is captured into the owner's rdata register at the closing edge.
- Next state after DATA is ACK.
- ACK (1 cycle):
  - Owner's ack=1; owner's err=1 only for a suppressed write.
  - The non-owner's ack and err stay 0.
  - Next state is IDLE.
- rdata registers:
  - The owner's rdata holds its value until that port's next read completes.
  - A write leaves rdata unchanged.
- Control strobes: c_memaddr, c_dataread and c_datawrite are mutually exclusive (at most one high per cycle) and all are 0 in IDLE and ACK.
- Latency: request sampled at edge 0 gives ADDR in cycle 1, DATA in cycle 2, ACK in cycle 3, IDLE in cycle 4. Peak throughput is one transaction per 4 cycles.
- Request inputs:
  - Sampled only in IDLE; changes during ADDR, DATA or ACK are ignored.
  - A request dropped before its ack still completes and acks.
  - A requester that keeps req high through ACK is re-arbitrated in IDLE. With PRIO_MODE=0 and both ports pending, the other port wins.
- Reads of PROT_ADDR are legal and return mem_rdata.

Test Plan:
- Port A write addr 8'h10 data 8'h5A, then read addr 8'h10 -> exact strobes:
  - Write: c_memaddr=1 in cycle 1 with mem_wdata=8'h10; c_datawrite=1 in cycle 2 with mem_wdata=8'h5A; a_ack=1 in cycle 3 with a_err=0.
  - Read: a_rdata=8'h5A when a_ack rises.
- a_req and b_req both held high continuously, PRIO_MODE=0 -> grants alternate A, B, A, B; each port sees one ack every 8 cycles; exactly one of a_ack/b_ack high at a time.
- Same stimulus as the previous scenario, PRIO_MODE=1 -> port A acked every 4 cycles; b_ack stays 0 while a_req is high.
- Port B write to 8'hFF, PROT_EN=1 -> c_datawrite stays 0 for the whole transaction; b_ack=1 with b_err=1 in cycle 3. A following read of 8'hFF returns the button value on mem_rdata.
- reset=0 asserted during the DATA cycle of a write -> c_datawrite=0 on the next cycle; no ack; all outputs 0 and busy=0. After release, a new request starts cleanly with A winning the first tie.
- a_req pulsed for one cycle only -> transaction still completes with a_ack in cycle 3; no second transaction follows.

Source files
------------

// File: rtl/datamem_arbiter.sv
// Two-port arbiter for the shared 8-bit data memory: turns req/ack transactions
// into address-load / read / write strobes and write-protects the button register.
module datamem_arbiter #(
   parameter bit         PRIO_MODE = 1'b0,
   parameter logic [7:0] PROT_ADDR = 8'hFF,
   parameter bit         PROT_EN   = 1'b1
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       a_req,
   input  logic       a_we,
   input  logic [7:0] a_addr,
   input  logic [7:0] a_wdata,
   output logic [7:0] a_rdata,
   output logic       a_ack,
   output logic       a_err,
   input  logic       b_req,
   input  logic       b_we,
   input  logic [7:0] b_addr,
   input  logic [7:0] b_wdata,
   output logic [7:0] b_rdata,
   output logic       b_ack,
   output logic       b_err,
   output logic [7:0] mem_wdata,
   input  logic [7:0] mem_rdata,
   output logic       c_memaddr,
   output logic       c_dataread,
   output logic       c_datawrite,
   output logic       owner,
   output logic       busy
);

   typedef enum logic [1:0] {IDLE, ADDR, DATA, ACK} state_t;

   state_t     state_q, state_d;
   logic       owner_q, owner_d;
   logic       we_q, we_d;
   logic [7:0] addr_q, addr_d;
   logic [7:0] wdata_q, wdata_d;
   logic [7:0] a_rdata_q, a_rdata_d;
   logic [7:0] b_rdata_q, b_rdata_d;
   logic       a_ack_q, a_ack_d;
   logic       b_ack_q, b_ack_d;
   logic       a_err_q, a_err_d;
   logic       b_err_q, b_err_d;
   logic [7:0] mem_wdata_q, mem_wdata_d;
   logic       c_memaddr_q, c_memaddr_d;
   logic       c_dataread_q, c_dataread_d;
   logic       c_datawrite_q, c_datawrite_d;
   logic       busy_q, busy_d;
   logic       grant_b;
   logic       prot_hit;

   assign prot_hit = PROT_EN && (addr_q == PROT_ADDR);

   // Outputs are computed for the state being entered, so each strobe is a flop
   // that lines up exactly with the state it belongs to.
   always_comb begin
      state_d       = state_q;
      owner_d       = owner_q;
      we_d          = we_q;
      addr_d        = addr_q;
      wdata_d       = wdata_q;
      a_rdata_d     = a_rdata_q;
      b_rdata_d     = b_rdata_q;
      a_ack_d       = 1'b0;
      b_ack_d       = 1'b0;
      a_err_d       = 1'b0;
      b_err_d       = 1'b0;
      mem_wdata_d   = 8'h00;
      c_memaddr_d   = 1'b0;
      c_dataread_d  = 1'b0;
      c_datawrite_d = 1'b0;
      grant_b       = owner_q;

      case (state_q)
         IDLE: begin
            if (a_req || b_req) begin
               if (PRIO_MODE)
                  grant_b = !a_req;
               else if (a_req && b_req)
                  grant_b = !owner_q;
               else
                  grant_b = b_req;
               owner_d     = grant_b;
               we_d        = grant_b ? b_we    : a_we;
               addr_d      = grant_b ? b_addr  : a_addr;
               wdata_d     = grant_b ? b_wdata : a_wdata;
               mem_wdata_d = grant_b ? b_addr  : a_addr;
               c_memaddr_d = 1'b1;
               state_d     = ADDR;
            end
         end
         ADDR: begin
            state_d = DATA;
            if (we_q) begin
               mem_wdata_d   = wdata_q;
               c_datawrite_d = !prot_hit;
            end else begin
               c_dataread_d = 1'b1;
            end
         end
         DATA: begin
            state_d = ACK;
            if (!we_q) begin
               if (owner_q)
                  b_rdata_d = mem_rdata;
               else
                  a_rdata_d = mem_rdata;
            end
            if (owner_q) begin
               b_ack_d = 1'b1;
               b_err_d = we_q && prot_hit;
            end else begin
               a_ack_d = 1'b1;
               a_err_d = we_q && prot_hit;
            end
         end
         ACK: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      busy_d = (state_d != IDLE);
   end

   // Owner resets to B so that A wins the first round-robin tie.
   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q       <= IDLE;
         owner_q       <= 1'b1;
         we_q          <= 1'b0;
         addr_q        <= 8'h00;
         wdata_q       <= 8'h00;
         a_rdata_q     <= 8'h00;
         b_rdata_q     <= 8'h00;
         a_ack_q       <= 1'b0;
         b_ack_q       <= 1'b0;
         a_err_q       <= 1'b0;
         b_err_q       <= 1'b0;
         mem_wdata_q   <= 8'h00;
         c_memaddr_q   <= 1'b0;
         c_dataread_q  <= 1'b0;
         c_datawrite_q <= 1'b0;
         busy_q        <= 1'b0;
      end else begin
         state_q       <= state_d;
         owner_q       <= owner_d;
         we_q          <= we_d;
         addr_q        <= addr_d;
         wdata_q       <= wdata_d;
         a_rdata_q     <= a_rdata_d;
         b_rdata_q     <= b_rdata_d;
         a_ack_q       <= a_ack_d;
         b_ack_q       <= b_ack_d;
         a_err_q       <= a_err_d;
         b_err_q       <= b_err_d;
         mem_wdata_q   <= mem_wdata_d;
         c_memaddr_q   <= c_memaddr_d;
         c_dataread_q  <= c_dataread_d;
         c_datawrite_q <= c_datawrite_d;
         busy_q        <= busy_d;
      end
   end

   assign a_rdata     = a_rdata_q;
   assign b_rdata     = b_rdata_q;
   assign a_ack       = a_ack_q;
   assign b_ack       = b_ack_q;
   assign a_err       = a_err_q;
   assign b_err       = b_err_q;
   assign mem_wdata   = mem_wdata_q;
   assign c_memaddr   = c_memaddr_q;
   assign c_dataread  = c_dataread_q;
   assign c_datawrite = c_datawrite_q;
   assign owner       = owner_q;
   assign busy        = busy_q;

endmodule

// File: tb/tb_datamem_arbiter.sv
// Directed bench for datamem_arbiter: a round-robin instance backed by a memory
// model, plus a fixed-priority instance sharing the same request inputs.
module tb_datamem_arbiter;

   logic       clk;
   logic       reset;
   logic       a_req, a_we, b_req, b_we;
   logic [7:0] a_addr, a_wdata, b_addr, b_wdata;
   logic [7:0] a_rdata, b_rdata, mem_wdata, mem_rdata;
   logic       a_ack, a_err, b_ack, b_err;
   logic       c_memaddr, c_dataread, c_datawrite, owner, busy;

   logic [7:0] p_a_rdata, p_b_rdata, p_mem_wdata;
   logic       p_a_ack, p_a_err, p_b_ack, p_b_err;
   logic       p_c_memaddr, p_c_dataread, p_c_datawrite, p_owner, p_busy;

   logic [7:0] mem [256];
   logic [7:0] mem_addr_reg;

   int passCount;
   int totalCount;

   typedef struct {
      logic       port;
      logic       we;
      logic [7:0] addr;
      logic [7:0] wdata;
      logic [7:0] exp_rdata;
      logic       exp_err;
   } vec_t;

   vec_t vecs [9];

   datamem_arbiter #(.PRIO_MODE(1'b0), .PROT_ADDR(8'hFF), .PROT_EN(1'b1)) dut (
      .clk(clk), .reset(reset),
      .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
      .a_rdata(a_rdata), .a_ack(a_ack), .a_err(a_err),
      .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
      .b_rdata(b_rdata), .b_ack(b_ack), .b_err(b_err),
      .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
      .c_memaddr(c_memaddr), .c_dataread(c_dataread), .c_datawrite(c_datawrite),
      .owner(owner), .busy(busy)
   );

   datamem_arbiter #(.PRIO_MODE(1'b1), .PROT_ADDR(8'hFF), .PROT_EN(1'b1)) dut_p (
      .clk(clk), .reset(reset),
      .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
      .a_rdata(p_a_rdata), .a_ack(p_a_ack), .a_err(p_a_err),
      .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
      .b_rdata(p_b_rdata), .b_ack(p_b_ack), .b_err(p_b_err),
      .mem_wdata(p_mem_wdata), .mem_rdata(8'h00),
      .c_memaddr(p_c_memaddr), .c_dataread(p_c_dataread), .c_datawrite(p_c_datawrite),
      .owner(p_owner), .busy(p_busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Memory model: address register loaded on c_memaddr, write on c_datawrite,
   // asynchronous read of the addressed location; the button register reads C3.
   always @(posedge clk) begin
      if (!reset) begin
         for (int k = 0; k < 256; k++) mem[k] <= 8'h00;
         mem[255]     <= 8'hC3;
         mem_addr_reg <= 8'h00;
      end else begin
         if (c_memaddr) mem_addr_reg <= mem_wdata;
         if (c_datawrite) mem[mem_addr_reg] <= mem_wdata;
      end
   end

   assign mem_rdata = mem[mem_addr_reg];

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      totalCount++;
      if (actual === expected)
         passCount++;
      else
         $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
   endtask

   task automatic applyStimulus(input int idx, input vec_t v);
      if (v.port) begin
         b_req = 1'b1; b_we = v.we; b_addr = v.addr; b_wdata = v.wdata;
      end else begin
         a_req = 1'b1; a_we = v.we; a_addr = v.addr; a_wdata = v.wdata;
      end
      @(posedge clk); #1;
      checkOutput($sformatf("v%0d_c1_memaddr", idx), c_memaddr, 1);
      checkOutput($sformatf("v%0d_c1_addr", idx), mem_wdata, v.addr);
      checkOutput($sformatf("v%0d_c1_owner", idx), owner, v.port);
      @(posedge clk); #1;
      if (v.we) begin
         checkOutput($sformatf("v%0d_c2_write", idx), c_datawrite, !v.exp_err);
         if (!v.exp_err)
            checkOutput($sformatf("v%0d_c2_wdata", idx), mem_wdata, v.wdata);
      end else begin
         checkOutput($sformatf("v%0d_c2_read", idx), {c_dataread, c_datawrite}, 2'b10);
      end
      checkOutput($sformatf("v%0d_c2_memaddr", idx), c_memaddr, 0);
      @(posedge clk); #1;
      checkOutput($sformatf("v%0d_c3_ack", idx), v.port ? {b_ack, a_ack} : {a_ack, b_ack}, 2'b10);
      checkOutput($sformatf("v%0d_c3_err", idx), v.port ? b_err : a_err, v.exp_err);
      checkOutput($sformatf("v%0d_c3_rdata", idx), v.port ? b_rdata : a_rdata, v.exp_rdata);
      checkOutput($sformatf("v%0d_c3_strobes", idx), {c_memaddr, c_dataread, c_datawrite}, 0);
      a_req = 1'b0;
      b_req = 1'b0;
      @(posedge clk); #1;
      checkOutput($sformatf("v%0d_c4_idle", idx), {busy, a_ack, b_ack}, 0);
   endtask

   initial begin
      passCount  = 0;
      totalCount = 0;
      reset = 1'b0;
      a_req = 1'b0; a_we = 1'b0; a_addr = 8'h00; a_wdata = 8'h00;
      b_req = 1'b0; b_we = 1'b0; b_addr = 8'h00; b_wdata = 8'h00;

      //            port  we    addr   wdata  exp_rdata exp_err
      vecs[0] = '{1'b0, 1'b1, 8'h10, 8'h5A, 8'h00, 1'b0};
      vecs[1] = '{1'b0, 1'b0, 8'h10, 8'h00, 8'h5A, 1'b0};
      vecs[2] = '{1'b1, 1'b1, 8'h20, 8'hA5, 8'h00, 1'b0};
      vecs[3] = '{1'b1, 1'b0, 8'h20, 8'h00, 8'hA5, 1'b0};
      vecs[4] = '{1'b1, 1'b1, 8'hFF, 8'h77, 8'hA5, 1'b1};
      vecs[5] = '{1'b1, 1'b0, 8'hFF, 8'h00, 8'hC3, 1'b0};
      vecs[6] = '{1'b0, 1'b0, 8'hFF, 8'h00, 8'hC3, 1'b0};
      vecs[7] = '{1'b0, 1'b1, 8'h30, 8'h3C, 8'hC3, 1'b0};
      vecs[8] = '{1'b1, 1'b0, 8'h30, 8'h00, 8'h3C, 1'b0};

      repeat (2) @(posedge clk);
      #1;
      checkOutput("reset_outputs",
                  {a_ack, b_ack, a_err, b_err, a_rdata, b_rdata, mem_wdata,
                   c_memaddr, c_dataread, c_datawrite, busy}, 0);
      checkOutput("reset_owner", owner, 1);
      reset = 1'b1;
      @(posedge clk); #1;

      for (int i = 0; i < 9; i++) applyStimulus(i, vecs[i]);

      // Both ports requesting continuously: round-robin alternates A,B and the
      // fixed-priority instance acks A every 4 cycles.
      reset = 1'b0;
      @(posedge clk); #1;
      reset = 1'b1;
      a_req = 1'b1; a_we = 1'b0; a_addr = 8'h10;
      b_req = 1'b1; b_we = 1'b0; b_addr = 8'h20;
      for (int c = 1; c <= 16; c++) begin
         @(posedge clk); #1;
         checkOutput($sformatf("arb_cycle%0d_acks", c), {a_ack, b_ack, p_a_ack, p_b_ack},
                     {(c % 8) == 3, (c % 8) == 7, (c % 4) == 3, 1'b0});
      end
      a_req = 1'b0;
      b_req = 1'b0;

      // Reset during the DATA cycle of a write abandons it without an ack.
      a_req = 1'b1; a_we = 1'b1; a_addr = 8'h40; a_wdata = 8'h99;
      @(posedge clk); #1;
      @(posedge clk); #1;
      checkOutput("rst_mid_c2_write", c_datawrite, 1);
      reset = 1'b0;
      @(posedge clk); #1;
      checkOutput("rst_mid_outputs",
                  {a_ack, b_ack, a_err, b_err, a_rdata, b_rdata, mem_wdata,
                   c_memaddr, c_dataread, c_datawrite, busy}, 0);
      checkOutput("rst_mid_owner", owner, 1);
      reset = 1'b1;
      a_we = 1'b0; a_addr = 8'hFF;
      b_req = 1'b1; b_we = 1'b0; b_addr = 8'h20;
      @(posedge clk); #1;
      checkOutput("rst_after_owner", owner, 0);
      @(posedge clk); #1;
      @(posedge clk); #1;
      checkOutput("rst_after_ack", {a_ack, b_ack}, 2'b10);
      checkOutput("rst_after_rdata", a_rdata, 8'hC3);
      a_req = 1'b0;
      b_req = 1'b0;
      @(posedge clk); #1;
      checkOutput("rst_after_idle", busy, 0);

      // One-cycle request pulse still completes exactly once.
      a_req = 1'b1; a_we = 1'b0; a_addr = 8'h10;
      @(posedge clk); #1;
      a_req = 1'b0;
      checkOutput("pulse_c1_busy", busy, 1);
      @(posedge clk); #1;
      @(posedge clk); #1;
      checkOutput("pulse_c3_ack", a_ack, 1);
      for (int c = 4; c <= 8; c++) begin
         @(posedge clk); #1;
         checkOutput($sformatf("pulse_c%0d_quiet", c), {busy, a_ack, b_ack}, 0);
      end

      $display("%0d/%0d checks passed", passCount, totalCount);
      $finish;
   end

endmodule
